scan_serializer: RTL and testbench

SCAN_SERIALIZER -- requirements
Module: scan_serializer

---
 rtl/scan_pkg.sv | 20 ++
 rtl/mux_8x1.sv | 10 +
 rtl/scan_serializer.sv | 66 ++++++
 tb/tb_scan_serializer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared widths, FSM states and bit-order constants for scan_serializer.
// Bit order follows SCAN_MSB_FIRST_EN (defined: MSB first; undefined: LSB first).
package scan_pkg;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`ifdef SCAN_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] SEL_START = 3'd7;
  localparam logic [SEL_W-1:0] SEL_END   = 3'd0;
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
    return s - 1'b1;
  endfunction
`else
  localparam logic [SEL_W-1:0] SEL_START = 3'd0;
  localparam logic [SEL_W-1:0] SEL_END   = 3'd7;
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
    return s + 1'b1;
  endfunction
`endif
endpackage

// File: rtl/mux_8x1.sv
// mux_8x1: combinational 8:1 bit select of the held word.
module mux_8x1
  import scan_pkg::*;
(
  input  logic [DATA_W-1:0] i,
  input  logic [SEL_W-1:0]  sel,
  output logic              out
);
  assign out = i[sel];
endmodule

// File: rtl/scan_serializer.sv
// scan_serializer: parallel-load, valid/ready bit serializer with optional idle gap.
// Bit order set by SCAN_MSB_FIRST_EN (see scan_pkg).
module scan_serializer
  import scan_pkg::*;
#(
  parameter int IDLE_GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              last,
  output logic [7:0]        word_cnt
);
  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);
  state_t            r_state;
  logic [DATA_W-1:0] r_hold;
  logic [SEL_W-1:0]  r_sel;
  logic [3:0]        r_gap;
  logic [7:0]        r_word_cnt;
  logic              w_beat;
  assign load_ready = r_state == IDLE;
  assign ser_valid  = r_state == SHIFT;
  assign last       = ser_valid && (r_sel == SEL_END);
  assign sel        = r_sel;
  assign word_cnt   = r_word_cnt;
  assign w_beat     = ser_valid && ser_ready;
  mux_8x1 u_mux (.i(r_hold), .sel(r_sel), .out(ser_out));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_sel      <= SEL_START;
      r_gap      <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (load_valid) begin
          r_hold  <= load_data;
          r_sel   <= SEL_START;
          r_state <= SHIFT;
        end
        SHIFT: if (w_beat) begin
          if (last) begin
            r_word_cnt <= r_word_cnt + 8'd1;
            r_sel      <= SEL_START;
            r_gap      <= '0;
            r_state    <= (IDLE_GAP > 0) ? GAP : IDLE;
          end else begin
            r_sel <= next_sel(r_sel);
          end
        end
        GAP: begin
          r_gap <= r_gap + 4'd1;
          if (r_gap == GAP_LAST) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_serializer.sv
// tb_scan_serializer: scoreboard bench for scan_serializer with IDLE_GAP=3.
// Expected bit order follows SCAN_MSB_FIRST_EN.
module tb_scan_serializer;
  localparam int GAP = 3;
`ifdef SCAN_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       ser_ready = 1'b1;
  logic       load_ready, ser_out, ser_valid, last;
  logic [2:0] sel;
  logic [7:0] word_cnt;
  typedef struct packed {logic b; logic [2:0] s; logic l;} beat_t;
  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int words_done = 0;
  int cnt_base = 0;
  scan_serializer #(.IDLE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .sel(sel), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .last(last), .word_cnt(word_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] idx(input int k);
    return MSB ? 3'(7 - k) : 3'(k);
  endfunction
  function automatic logic [7:0] exp_cnt();
    return 8'(words_done - cnt_base);
  endfunction
  always @(negedge clk) begin
    beat_t e;
    if (!rst && ser_valid && ser_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got ser_out=%b sel=%0d last=%b, expected no beat", ser_out, sel, last);
      end else begin
        e = sb.pop_front();
        if ({ser_out, sel, last} !== {e.b, e.s, e.l}) begin
          errors++;
          $display("FAIL beat: got ser_out=%b sel=%0d last=%b, expected ser_out=%b sel=%0d last=%b",
                   ser_out, sel, last, e.b, e.s, e.l);
        end
        if (e.l) words_done++;
      end
    end
  end
  task automatic push_word(input logic [7:0] d);
    for (int k = 0; k < 8; k++) sb.push_back(beat_t'{b: d[idx(k)], s: idx(k), l: (k == 7)});
  endtask
  task automatic send(input logic [7:0] d, input bit noise);
    bit ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = load_ready;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_ready_timeout: load_ready=%b, expected 1", load_ready);
      return;
    end
    load_valid = 1'b1;
    load_data = d;
    @(posedge clk);
    push_word(d);
    #1 load_valid = 1'b0;
    if (noise) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data = ~d;
      repeat (3) @(negedge clk);
      load_valid = 1'b0;
    end
  endtask
  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats pending, expected 0", sb.size());
    end
  endtask
  task automatic check_cnt(input string name);
    checks++;
    if (word_cnt !== exp_cnt()) begin
      errors++;
      $display("FAIL %s: word_cnt=%0d, expected %0d", name, word_cnt, exp_cnt());
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_ready, ser_valid, last, sel} !== {1'b1, 1'b0, 1'b0, idx(0)}) begin
      errors++;
      $display("FAIL reset_state: load_ready=%b ser_valid=%b last=%b sel=%0d, expected 1 0 0 %0d",
               load_ready, ser_valid, last, sel, idx(0));
    end
    check_cnt("reset_word_cnt");
  endtask
  task automatic test_words();
    int n = 0;
    send(8'hA5, 1'b0);
    @(negedge clk);
    checks++;
    if (ser_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_beat_latency: ser_valid=%b, expected 1", ser_valid);
    end
    while (ser_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL beat_run_length: %0d consecutive beats, expected 8", n);
    end
    check_cnt("word_cnt_after_a5");
    send(8'h01, 1'b0);
    drain();
    check_cnt("word_cnt_after_01");
  endtask
  task automatic test_backpressure();
    logic [7:0] d = 8'h3C;
    send(d, 1'b0);
    repeat (2) @(posedge clk);
    #1 ser_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({ser_valid, sel, ser_out, last} !== {1'b1, idx(2), d[idx(2)], 1'b0}) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d ser_valid=%b sel=%0d ser_out=%b last=%b, expected 1 %0d %b 0",
                 c, ser_valid, sel, ser_out, last, idx(2), d[idx(2)]);
      end
    end
    @(posedge clk);
    #1 ser_ready = 1'b1;
    drain();
    check_cnt("word_cnt_after_stall");
  endtask
  task automatic test_back_to_back();
    int n = 0;
    int gap_seen = 0;
    send(8'h96, 1'b0);
    load_valid = 1'b1;
    load_data = 8'h4B;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!ser_valid && !load_ready) gap_seen++;
      if (load_ready) break;
    end
    checks++;
    if (n + 1 != 9 + GAP) begin
      errors++;
      $display("FAIL word_period: %0d cycles between handshakes, expected %0d", n + 1, 9 + GAP);
    end
    checks++;
    if (gap_seen != GAP) begin
      errors++;
      $display("FAIL gap_length: %0d gap cycles, expected %0d", gap_seen, GAP);
    end
    @(posedge clk);
    push_word(8'h4B);
    #1 load_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ser_valid !== 1'b1) begin
      errors++;
      $display("FAIL second_word_first_beat: ser_valid=%b, expected 1", ser_valid);
    end
    drain();
    check_cnt("word_cnt_after_b2b");
  endtask
  task automatic test_reset_mid();
    send(8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    cnt_base = words_done;
    checks++;
    if ({ser_valid, last, word_cnt} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL async_reset: ser_valid=%b last=%b word_cnt=%0d, expected 0 0 0", ser_valid, last, word_cnt);
    end
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({ser_valid, load_ready} !== 2'b01) begin
        errors++;
        $display("FAIL post_reset_idle: ser_valid=%b load_ready=%b, expected 0 1", ser_valid, load_ready);
      end
    end
    check_cnt("word_cnt_after_reset");
  endtask
  task automatic test_wrap();
    for (int w = 0; w < 255; w++) send(8'($urandom), (w % 4) == 0);
    drain();
    check_cnt("word_cnt_255");
    send(8'h5A, 1'b1);
    drain();
    check_cnt("word_cnt_wrap");
    checks++;
    if (word_cnt !== 8'h00) begin
      errors++;
      $display("FAIL wrap_zero: word_cnt=%0d, expected 0", word_cnt);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_words();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
